axi_burst_ctrl: RTL and testbench
=================================

Name: axi_burst_ctrl

Overview:
- Single-outstanding AXI4 burst master controller.
- Accepts one read or write command at a time on a simple valid/ready command port.
- Sequences the AR/R or AW/W/B channels on the AXI master port and streams data to/from the local client.
- Sits between a local engine (DMA or test sequencer) and an AXI slave such as the testbench slave model or the memory interconnect.

Parameters:
- ADDR_W, 32, AXI address width
- DATA_W, 32, data width; WSTRB width = DATA_W/8
- AXSIZE, 3'd2, fixed AxSIZE driven on AW/AR (log2 of DATA_W/8)

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- CMD_VALID  in  1  command request
- CMD_READY  out  1  command accepted when VALID&READY
- CMD_WRITE  in  1  1=write, 0=read
- CMD_ADDR  in  ADDR_W  start byte address
- CMD_LEN  in  8  beats minus one (AxLEN)
- WR_DATA  in  DATA_W  client write data
- WR_VALID  in  1  client write data valid
- WR_READY  out  1  client write beat consumed
- RD_DATA  out  DATA_W  read data to client
- RD_VALID  out  1  read beat valid
- RD_LAST  out  1  last read beat
- RD_READY  in  1  client accepts read beat
- DONE  out  1  one-cycle pulse at command completion
- DONE_RESP  out  2  worst response of the command (held until next DONE)
- DONE_LENERR  out  1  RLAST position mismatch (held until next DONE)
- M_AXI_AWADDR/AWLEN/AWVALID  out  ADDR_W/8/1; M_AXI_AWREADY  in  1
- M_AXI_WDATA/WSTRB/WLAST/WVALID  out  DATA_W/DATA_W/8/1/1; M_AXI_WREADY  in  1
- M_AXI_BRESP  in  2; M_AXI_BVALID  in  1; M_AXI_BREADY  out  1
- M_AXI_ARADDR/ARLEN/ARVALID  out  ADDR_W/8/1; M_AXI_ARREADY  in  1
- M_AXI_RDATA  in  DATA_W; M_AXI_RRESP  in  2; M_AXI_RLAST  in  1; M_AXI_RVALID  in  1; M_AXI_RREADY  out  1
- Constant outputs: AWID/ARID=0, AWSIZE/ARSIZE=AXSIZE, AWBURST/ARBURST=2'b01 (INCR), AWLOCK/ARLOCK=0, AWCACHE/ARCACHE=4'b0011, AWPROT/ARPROT=0, AWQOS/ARQOS=0, AWUSER/ARUSER/WUSER=0

Behaviour:
- Clocking/reset: one clock ACLK; reset is asynchronous, active-low on ARESETN.
- Reset values: state IDLE; all VALIDs, BREADY, DONE, DONE_LENERR = 0; DONE_RESP = 0; beat counter = 0.
- CMD_READY = (state==IDLE), combinational.
- Reset mid-burst abandons the transaction immediately; no recovery of slave state is attempted.
- FSM states: IDLE, AR, R, AW, W, B, FIN.
  - IDLE: on CMD_VALID, register addr/len/write, clear beat count, resp accumulator and lenerr; go AW if write, else AR.
  - AR: ARVALID=1 (registered; ARADDR/ARLEN from command registers); on ARREADY go R.
  - R: RREADY = RD_READY, combinational. RREADY must not depend on RVALID, since slaves may gate RVALID on RREADY.
    - RD_DATA/RD_VALID/RD_LAST pass through RDATA/RVALID/RLAST.
    - Each RVALID&RREADY: count++, resp_acc = max(resp_acc, RRESP).
    - On a beat with RLAST: lenerr = (count != len); go FIN.
    - On beat count == len without RLAST: set lenerr, stay in R until RLAST.
  - AW: AWVALID=1; on AWREADY go W. AW always completes before any W beat (no AW/W overlap).
  - W: WVALID = WR_VALID; WR_READY = M_AXI_WREADY; WDATA = WR_DATA; WSTRB all ones; WLAST = (count==len). Both combinational, gated by state==W.
    - Each WVALID&WREADY: count++; on the WLAST beat go B.
  - B: BREADY=1 (registered); on BVALID capture BRESP and go FIN.
  - FIN: DONE=1 for one cycle; DONE_RESP/DONE_LENERR updated; next state IDLE.
- Latency: a new command is accepted at the earliest one cycle after FIN (CMD_READY low during FIN).
- Once asserted, ARVALID/AWVALID hold until their READY; address/len are stable throughout.
- CMD_LEN=0: single beat, WLAST/RLAST expected on beat 0.
- CMD_LEN=255: counter is 9 bits so no wrap; 256 beats.
- No 4 KB boundary splitting; the issuer must not cross 4 KB.
- CMD_VALID while busy is ignored (no queueing).

Test Plan:
- Read, addr 0x1000, len 3, RD_READY=1, slave returns RDATA 0..3 with RLAST on 4th beat -> one AR with ARLEN=3; RD_VALID 4 beats data 0,1,2,3; RD_LAST on beat 4; DONE pulse with RESP=0, LENERR=0.
- Write, len 0, WR_VALID=1, data 0xA5A5A5A5 -> AWLEN=0; single W beat with WLAST=1, WSTRB=4'hF; BREADY high until BVALID; DONE, RESP=0.
- Read len 7 with RD_READY toggling 1/0 each cycle -> RREADY mirrors RD_READY; exactly 8 beats consumed; no beat lost or duplicated; DONE after 8th handshake.
- Read len 3, slave asserts RLAST on beat 2 (RRESP=2 on beat 1) -> FIN after beat 2; DONE_LENERR=1, DONE_RESP=2.
- CMD_VALID held high through a write of len 15 -> CMD_READY=0 from accept to the cycle after FIN; second command accepted exactly 1 cycle after DONE.
- ARESETN pulsed low during W beat 5 of len 15 -> all VALIDs and BREADY go 0 asynchronously; state IDLE; CMD_READY=1 after release.

Source files
------------

// File: rtl/axi_burst_ctrl.sv
// axi_burst_ctrl: single-outstanding AXI4 INCR burst master; one read or write command at a time.
module axi_burst_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [2:0] AXSIZE = 3'd2
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                CMD_VALID,
  output logic                CMD_READY,
  input  logic                CMD_WRITE,
  input  logic [ADDR_W-1:0]   CMD_ADDR,
  input  logic [7:0]          CMD_LEN,
  input  logic [DATA_W-1:0]   WR_DATA,
  input  logic                WR_VALID,
  output logic                WR_READY,
  output logic [DATA_W-1:0]   RD_DATA,
  output logic                RD_VALID,
  output logic                RD_LAST,
  input  logic                RD_READY,
  output logic                DONE,
  output logic [1:0]          DONE_RESP,
  output logic                DONE_LENERR,
  output logic [3:0]          M_AXI_AWID,
  output logic [ADDR_W-1:0]   M_AXI_AWADDR,
  output logic [7:0]          M_AXI_AWLEN,
  output logic [2:0]          M_AXI_AWSIZE,
  output logic [1:0]          M_AXI_AWBURST,
  output logic                M_AXI_AWLOCK,
  output logic [3:0]          M_AXI_AWCACHE,
  output logic [2:0]          M_AXI_AWPROT,
  output logic [3:0]          M_AXI_AWQOS,
  output logic                M_AXI_AWUSER,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WLAST,
  output logic                M_AXI_WUSER,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,
  output logic [3:0]          M_AXI_ARID,
  output logic [ADDR_W-1:0]   M_AXI_ARADDR,
  output logic [7:0]          M_AXI_ARLEN,
  output logic [2:0]          M_AXI_ARSIZE,
  output logic [1:0]          M_AXI_ARBURST,
  output logic                M_AXI_ARLOCK,
  output logic [3:0]          M_AXI_ARCACHE,
  output logic [2:0]          M_AXI_ARPROT,
  output logic [3:0]          M_AXI_ARQOS,
  output logic                M_AXI_ARUSER,
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,
  input  logic [DATA_W-1:0]   M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RLAST,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY
);
  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, FIN} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        len;
  logic [8:0]        cnt;
  logic [1:0]        resp_acc, resp_n;
  logic              lenerr, lenerr_n;
  logic              arvalid, awvalid, bready, done;
  logic              r_beat, w_beat, at_len;

  assign at_len = cnt == {1'b0, len};
  assign r_beat = state == R && M_AXI_RVALID && RD_READY;
  assign w_beat = state == W && WR_VALID && M_AXI_WREADY;

  always_comb begin
    state_n  = state;
    resp_n   = resp_acc;
    lenerr_n = lenerr;
    unique case (state)
      IDLE: state_n = CMD_VALID ? (CMD_WRITE ? AW : AR) : IDLE;
      AR:   state_n = M_AXI_ARREADY ? R : AR;
      R: if (r_beat) begin
        resp_n = M_AXI_RRESP > resp_acc ? M_AXI_RRESP : resp_acc;
        // an RLAST at the wrong beat, or a missing one at the expected beat, both flag a length error
        lenerr_n = M_AXI_RLAST ? lenerr | !at_len : lenerr | at_len;
        state_n = M_AXI_RLAST ? FIN : R;
      end
      AW:   state_n = M_AXI_AWREADY ? W : AW;
      W:    state_n = w_beat && at_len ? B : W;
      B: if (M_AXI_BVALID) begin
        resp_n  = M_AXI_BRESP;
        state_n = FIN;
      end
      FIN:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state       <= IDLE;
      addr        <= '0;
      len         <= '0;
      cnt         <= '0;
      resp_acc    <= '0;
      lenerr      <= 1'b0;
      arvalid     <= 1'b0;
      awvalid     <= 1'b0;
      bready      <= 1'b0;
      done        <= 1'b0;
      DONE_RESP   <= '0;
      DONE_LENERR <= 1'b0;
    end else begin
      state    <= state_n;
      resp_acc <= resp_n;
      lenerr   <= lenerr_n;
      arvalid  <= state_n == AR;
      awvalid  <= state_n == AW;
      bready   <= state_n == B;
      done     <= state_n == FIN;
      if (state == IDLE && CMD_VALID) begin
        addr     <= CMD_ADDR;
        len      <= CMD_LEN;
        cnt      <= '0;
        resp_acc <= '0;
        lenerr   <= 1'b0;
      end else if (r_beat || w_beat) begin
        cnt <= cnt + 9'd1;
      end
      if (state_n == FIN) begin
        DONE_RESP   <= resp_n;
        DONE_LENERR <= lenerr_n;
      end
    end
  end

  assign CMD_READY     = state == IDLE;
  assign DONE          = done;
  assign WR_READY      = state == W && M_AXI_WREADY;
  assign RD_DATA       = M_AXI_RDATA;
  assign RD_VALID      = state == R && M_AXI_RVALID;
  assign RD_LAST       = M_AXI_RLAST;
  assign M_AXI_RREADY  = state == R && RD_READY;
  assign M_AXI_ARVALID = arvalid;
  assign M_AXI_ARADDR  = addr;
  assign M_AXI_ARLEN   = len;
  assign M_AXI_AWVALID = awvalid;
  assign M_AXI_AWADDR  = addr;
  assign M_AXI_AWLEN   = len;
  assign M_AXI_WVALID  = state == W && WR_VALID;
  assign M_AXI_WDATA   = WR_DATA;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = state == W && at_len;
  assign M_AXI_BREADY  = bready;
  assign M_AXI_AWID    = '0;
  assign M_AXI_ARID    = '0;
  assign M_AXI_AWSIZE  = AXSIZE;
  assign M_AXI_ARSIZE  = AXSIZE;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_AWCACHE = 4'b0011;
  assign M_AXI_ARCACHE = 4'b0011;
  assign M_AXI_AWPROT  = '0;
  assign M_AXI_ARPROT  = '0;
  assign M_AXI_AWQOS   = '0;
  assign M_AXI_ARQOS   = '0;
  assign M_AXI_AWUSER  = 1'b0;
  assign M_AXI_ARUSER  = 1'b0;
  assign M_AXI_WUSER   = 1'b0;
endmodule

// File: tb/tb_axi_burst_ctrl.sv
// tb_axi_burst_ctrl: directed commands against a queue-driven AXI slave/client model with per-cycle checking.
module tb_axi_burst_ctrl;
  logic ACLK = 0, ARESETN = 0;
  always #5 ACLK = ~ACLK;

  logic CMD_VALID = 0, CMD_READY, CMD_WRITE = 0;
  logic [31:0] CMD_ADDR = 0;
  logic [7:0] CMD_LEN = 0;
  logic [31:0] WR_DATA = 0, RD_DATA;
  logic WR_VALID = 0, WR_READY, RD_VALID, RD_LAST, RD_READY = 1, DONE, DONE_LENERR;
  logic [1:0] DONE_RESP;
  logic [3:0] AWID, ARID, AWCACHE, ARCACHE, AWQOS, ARQOS, WSTRB;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA = 0;
  logic [7:0] AWLEN, ARLEN;
  logic [2:0] AWSIZE, ARSIZE, AWPROT, ARPROT;
  logic [1:0] AWBURST, ARBURST, BRESP = 0, RRESP = 0;
  logic AWLOCK, ARLOCK, AWUSER, ARUSER, WUSER, AWVALID, ARVALID, WVALID, WLAST, BREADY, RREADY;
  logic AWREADY = 0, ARREADY = 0, WREADY = 0, BVALID = 0, RVALID = 0, RLAST = 0;

  axi_burst_ctrl dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_WRITE(CMD_WRITE), .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN),
    .WR_DATA(WR_DATA), .WR_VALID(WR_VALID), .WR_READY(WR_READY),
    .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .RD_LAST(RD_LAST), .RD_READY(RD_READY),
    .DONE(DONE), .DONE_RESP(DONE_RESP), .DONE_LENERR(DONE_LENERR),
    .M_AXI_AWID(AWID), .M_AXI_AWADDR(AWADDR), .M_AXI_AWLEN(AWLEN), .M_AXI_AWSIZE(AWSIZE),
    .M_AXI_AWBURST(AWBURST), .M_AXI_AWLOCK(AWLOCK), .M_AXI_AWCACHE(AWCACHE), .M_AXI_AWPROT(AWPROT),
    .M_AXI_AWQOS(AWQOS), .M_AXI_AWUSER(AWUSER), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WLAST(WLAST), .M_AXI_WUSER(WUSER),
    .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
    .M_AXI_ARID(ARID), .M_AXI_ARADDR(ARADDR), .M_AXI_ARLEN(ARLEN), .M_AXI_ARSIZE(ARSIZE),
    .M_AXI_ARBURST(ARBURST), .M_AXI_ARLOCK(ARLOCK), .M_AXI_ARCACHE(ARCACHE), .M_AXI_ARPROT(ARPROT),
    .M_AXI_ARQOS(ARQOS), .M_AXI_ARUSER(ARUSER), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RLAST(RLAST), .M_AXI_RVALID(RVALID),
    .M_AXI_RREADY(RREADY)
  );

  int n_vec = 0, n_err = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic miss(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got unexpected event or timeout, expected none (t=%0t)", name, $time);
  endtask

  // expectations (model) and slave/client stimulus queues
  logic [39:0] exp_ar[$], exp_aw[$];
  logic [32:0] exp_w[$], exp_r[$];
  logic [2:0]  exp_done[$];
  logic [34:0] rq[$];
  logic [31:0] wq[$];
  logic [1:0]  bq[$];

  bit r_act, w_act, b_pend, ar_seen, aw_seen, rd_toggle, w_stall;
  bit ar_hs, aw_hs, r_hs, r_last_hs, wl_hs, wr_hs, b_hs;
  int b_wait, cyc;

  always begin
    @(negedge ACLK);
    cyc++;
    if (!ARESETN) begin
      {r_act, w_act, b_pend, ar_seen, aw_seen} = '0;
      {ar_hs, aw_hs, r_hs, r_last_hs, wl_hs, wr_hs, b_hs} = '0;
      rq.delete(); wq.delete(); bq.delete();
    end else begin
      if (ar_hs) r_act = 1;
      if (r_hs) begin
        if (r_last_hs) r_act = 0;
        void'(rq.pop_front());
      end
      if (aw_hs) w_act = 1;
      if (wr_hs) void'(wq.pop_front());
      if (wl_hs) begin w_act = 0; b_pend = 1; b_wait = 2; end
      if (b_hs) begin b_pend = 0; void'(bq.pop_front()); end
    end
    ARREADY = ar_seen;
    AWREADY = aw_seen;
    RVALID = r_act && rq.size() > 0;
    {RDATA, RRESP, RLAST} = rq.size() > 0 ? rq[0] : '0;
    WREADY = w_act && (!w_stall || cyc[0]);
    BVALID = b_pend && b_wait == 0;
    BRESP = bq.size() > 0 ? bq[0] : 2'b00;
    if (b_pend && b_wait > 0) b_wait--;
    WR_VALID = wq.size() > 0;
    WR_DATA = WR_VALID ? wq[0] : '0;
    RD_READY = rd_toggle ? !RD_READY : 1'b1;
    #1;
    ar_hs = ARVALID && ARREADY;  ar_seen = ARVALID && !ARREADY;
    aw_hs = AWVALID && AWREADY;  aw_seen = AWVALID && !AWREADY;
    r_hs = RVALID && RREADY;     r_last_hs = r_hs && RLAST;
    wl_hs = WVALID && WREADY && WLAST;
    wr_hs = WR_VALID && WR_READY;
    b_hs = BVALID && BREADY;
  end

  bit busy;
  int n_done, n_wb, n_rb, cyc_done, cyc_acc;
  logic [31:0] rlog[$];

  always begin
    @(negedge ACLK);
    #2;
    if (!ARESETN) begin
      chk("rst_outputs", {ARVALID, AWVALID, WVALID, BREADY, RREADY, DONE}, 6'b0);
      busy = 0;
    end else begin
      chk("cmd_ready", CMD_READY, !busy);
      chk("rready", RREADY, r_act && RD_READY);
      chk("wr_ready", WR_READY, w_act && WREADY);
      chk("bready", BREADY, b_pend);
      if (CMD_VALID && CMD_READY) begin busy = 1; cyc_acc = cyc; end
      if (ARVALID && ARREADY) begin
        if (exp_ar.size() == 0) miss("ar_extra"); else chk("ar_addr_len", {ARADDR, ARLEN}, exp_ar.pop_front());
      end
      if (AWVALID && AWREADY) begin
        if (exp_aw.size() == 0) miss("aw_extra"); else chk("aw_addr_len", {AWADDR, AWLEN}, exp_aw.pop_front());
      end
      if (WVALID && WREADY) begin
        n_wb++;
        chk("wstrb", WSTRB, 4'hF);
        if (exp_w.size() == 0) miss("w_extra"); else chk("w_data_last", {WDATA, WLAST}, exp_w.pop_front());
      end
      if (RD_VALID && RD_READY) begin
        n_rb++;
        rlog.push_back(RD_DATA);
        if (exp_r.size() == 0) miss("r_extra"); else chk("rd_data_last", {RD_DATA, RD_LAST}, exp_r.pop_front());
      end
      if (DONE) begin
        n_done++;
        busy = 0;
        cyc_done = cyc;
        if (exp_done.size() == 0) miss("done_extra"); else chk("done_resp_lenerr", {DONE_RESP, DONE_LENERR}, exp_done.pop_front());
      end
    end
  end

  task automatic plan_read(input logic [31:0] a, input int len, input int last_at, input int bad,
                           input logic [1:0] bad_resp, input logic [31:0] base);
    logic [1:0] worst, rr;
    logic [31:0] d;
    worst = 2'b00;
    exp_ar.push_back({a, 8'(len)});
    for (int i = 0; i <= last_at; i++) begin
      rr = i == bad ? bad_resp : 2'b00;
      d = base + 32'(i);
      rq.push_back({d, rr, i == last_at});
      exp_r.push_back({d, i == last_at});
      if (rr > worst) worst = rr;
    end
    exp_done.push_back({worst, last_at != len});
  endtask

  task automatic plan_write(input logic [31:0] a, input int len, input logic [31:0] base, input logic [1:0] br);
    exp_aw.push_back({a, 8'(len)});
    for (int i = 0; i <= len; i++) begin
      wq.push_back(base + 32'(i));
      exp_w.push_back({base + 32'(i), i == len});
    end
    bq.push_back(br);
    exp_done.push_back({br, 1'b0});
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [7:0] l);
    @(negedge ACLK);
    CMD_WRITE = w; CMD_ADDR = a; CMD_LEN = l; CMD_VALID = 1;
    for (int t = 0; ; t++) begin
      #1;
      if (CMD_READY) break;
      if (t == 50) begin miss("cmd_accept_timeout"); break; end
      @(negedge ACLK);
    end
    @(negedge ACLK);
    CMD_VALID = 0;
  endtask

  task automatic wait_done(input int target);
    for (int t = 0; t < 3000 && n_done < target; t++) @(negedge ACLK);
    if (n_done < target) miss("done_timeout");
  endtask

  task automatic go(input logic w, input logic [31:0] a, input logic [7:0] l);
    int d0;
    d0 = n_done;
    issue(w, a, l);
    wait_done(d0 + 1);
  endtask

  int rb0, wb0, rl0, d0, a0;
  initial begin
    repeat (3) @(negedge ACLK);
    #1;
    chk("reset_cmd_ready", CMD_READY, 1'b1);
    chk("reset_done_resp", {DONE, DONE_RESP, DONE_LENERR}, 4'b0);
    chk("const_aw", {AWBURST, AWSIZE, AWCACHE, AWID, AWLOCK}, {2'b01, 3'd2, 4'b0011, 4'd0, 1'b0});
    chk("const_ar", {ARBURST, ARSIZE, ARCACHE, ARPROT, ARQOS}, {2'b01, 3'd2, 4'b0011, 3'd0, 4'd0});
    @(negedge ACLK);
    #3 ARESETN = 1;

    rb0 = n_rb; rl0 = rlog.size();
    plan_read(32'h1000, 3, 3, -1, 2'b00, 32'h0);
    go(0, 32'h1000, 8'd3);
    chk("t1_beats", n_rb - rb0, 4);
    chk("t1_data", {rlog[rl0], rlog[rl0+1], rlog[rl0+2], rlog[rl0+3]}, {32'd0, 32'd1, 32'd2, 32'd3});
    chk("t1_resp", {DONE_RESP, DONE_LENERR}, 3'b000);

    wb0 = n_wb;
    plan_write(32'h2000, 0, 32'hA5A5A5A5, 2'b00);
    go(1, 32'h2000, 8'd0);
    chk("t2_beats", n_wb - wb0, 1);

    rb0 = n_rb; rl0 = rlog.size();
    rd_toggle = 1;
    plan_read(32'h3000, 7, 7, -1, 2'b00, 32'h100);
    go(0, 32'h3000, 8'd7);
    rd_toggle = 0;
    chk("t3_beats", n_rb - rb0, 8);
    chk("t3_last_data", rlog[rl0+7], 32'h107);

    plan_read(32'h4000, 3, 2, 1, 2'b10, 32'h200);
    go(0, 32'h4000, 8'd3);
    chk("t4_early_rlast", {DONE_RESP, DONE_LENERR}, 3'b101);

    plan_read(32'h5000, 1, 2, -1, 2'b00, 32'h300);
    go(0, 32'h5000, 8'd1);
    chk("t5_late_rlast", {DONE_RESP, DONE_LENERR}, 3'b001);

    w_stall = 1;
    plan_write(32'h6000, 5, 32'h600, 2'b10);
    go(1, 32'h6000, 8'd5);
    w_stall = 0;
    chk("t6_bresp", {DONE_RESP, DONE_LENERR}, 3'b100);

    rb0 = n_rb;
    plan_read(32'h7000, 255, 255, 200, 2'b01, 32'h10000);
    go(0, 32'h7000, 8'd255);
    chk("t7_beats", n_rb - rb0, 256);
    chk("t7_resp", {DONE_RESP, DONE_LENERR}, 3'b010);

    // CMD_VALID held through a busy write; the queued read must land one cycle after DONE
    d0 = n_done;
    plan_write(32'h8000, 15, 32'h800, 2'b00);
    plan_read(32'h9000, 0, 0, -1, 2'b00, 32'h900);
    @(negedge ACLK);
    CMD_WRITE = 1; CMD_ADDR = 32'h8000; CMD_LEN = 8'd15; CMD_VALID = 1;
    for (int t = 0; t < 50 && !busy; t++) @(negedge ACLK);
    a0 = cyc_acc;
    CMD_WRITE = 0; CMD_ADDR = 32'h9000; CMD_LEN = 8'd0;
    for (int t = 0; t < 500 && cyc_acc == a0; t++) @(negedge ACLK);
    CMD_VALID = 0;
    chk("t8_accept_gap", cyc_acc - cyc_done, 1);
    wait_done(d0 + 2);

    wb0 = n_wb;
    plan_write(32'hA000, 15, 32'hA00, 2'b00);
    issue(1, 32'hA000, 8'd15);
    for (int t = 0; t < 200 && n_wb - wb0 < 5; t++) @(negedge ACLK);
    chk("t9_beats_before_reset", n_wb - wb0, 5);
    #3 ARESETN = 0;
    #1;
    chk("t9_async_clear", {ARVALID, AWVALID, WVALID, BREADY, RREADY, WR_READY}, 6'b0);
    chk("t9_idle_in_reset", CMD_READY, 1'b1);
    exp_ar.delete(); exp_aw.delete(); exp_w.delete(); exp_r.delete(); exp_done.delete();
    repeat (2) @(negedge ACLK);
    #3 ARESETN = 1;
    #1;
    chk("t9_ready_after_release", CMD_READY, 1'b1);
    plan_read(32'hB000, 1, 1, -1, 2'b00, 32'hB00);
    go(0, 32'hB000, 8'd1);
    chk("t9_recovery", {DONE_RESP, DONE_LENERR}, 3'b000);

    repeat (3) @(negedge ACLK);
    chk("leftover_expect", exp_ar.size() + exp_aw.size() + exp_w.size() + exp_r.size() + exp_done.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
